// File: rtl/ocram_pkg.sv
// Shared state encoding and elaboration-time helpers for the burst-capable on-chip RAM.
package ocram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        RBURST
    } ocram_state_e;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Cycles from read issue to readdatavalid.
    function automatic int ocram_latency(input int out_reg);
        return 1 + out_reg;
    endfunction

endpackage

// File: rtl/ocram_be_ram.sv
// Single-port synchronous RAM with per-byte write enables and clock enable.
// Read data appears one cycle after issue; write beats take priority over reads.
module ocram_be_ram #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 13,
    parameter string INIT_FILE = ""
) (
    input  logic                clk_i,
    input  logic                ce_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                re_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            if (we_i) begin
                for (int b = 0; b < NB; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else if (re_i) begin
                rdata_o <= mem_q[addr_i];
            end
        end
    end

endmodule

// File: rtl/ocram_burst_slave.sv
// Avalon-MM on-chip RAM slave with incrementing bursts; read latency 1+OUT_REG.
// Stall (clken low or reset_req) freezes everything and raises waitrequest; read bursts hold waitrequest.
module ocram_burst_slave
    import ocram_pkg::*;
#(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 13,
    parameter int    MAX_BURST = 8,
    parameter int    OUT_REG   = 0,
    parameter string INIT_FILE = "",
    localparam int   BC_W      = clog2(MAX_BURST) + 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                reset_req,
    input  logic                clken,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [BC_W-1:0]     burstcount,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest
);

    localparam int                LATENCY  = ocram_latency(OUT_REG);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [BC_W-1:0]   BC_ONE   = 1;

    ocram_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic [BC_W-1:0]    rem_q, rem_d;
    logic [LATENCY-1:0] vld_q, vld_d;
    logic               ready_q;
    logic [DATA_W-1:0]  hold_q;
    logic [DATA_W-1:0]  ram_q, stage_dat;
    logic [ADDR_W-1:0]  ram_addr;
    logic [BC_W-1:0]    bc_eff;
    logic               stall, accept, ram_ce, ram_we, ram_re;

    assign stall       = ~clken | reset_req;
    assign ram_ce      = ~stall;
    // ready_q keeps waitrequest high through reset and the first cycle after release.
    assign waitrequest = stall | ~ready_q | (state_q == RBURST);
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign bc_eff      = (burstcount == '0) ? BC_ONE : burstcount;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        ram_addr = ptr_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ram_addr = address;
                    ram_we   = write;
                    ram_re   = ~write;
                    if (bc_eff != BC_ONE) begin
                        ptr_d   = address + ADDR_ONE;
                        rem_d   = bc_eff - BC_ONE;
                        state_d = write ? WBURST : RBURST;
                    end
                end
            end
            WBURST: begin
                if (~stall & chipselect & write) begin
                    ram_we = 1'b1;
                    ptr_d  = ptr_q + ADDR_ONE;
                    rem_d  = rem_q - BC_ONE;
                    if (rem_q == BC_ONE) state_d = IDLE;
                end
            end
            RBURST: begin
                if (~stall) begin
                    ram_re = 1'b1;
                    ptr_d  = ptr_q + ADDR_ONE;
                    rem_d  = rem_q - BC_ONE;
                    if (rem_q == BC_ONE) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_d    = '0;
        vld_d[0] = ram_re;
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            vld_q   <= '0;
            ready_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            if (!stall) begin
                state_q <= state_d;
                ptr_q   <= ptr_d;
                rem_q   <= rem_d;
                vld_q   <= vld_d;
            end
            if (readdatavalid) hold_q <= stage_dat;
        end
    end

    ocram_be_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk_i   (clk),
        .ce_i    (ram_ce),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .be_i    (byteenable),
        .wdata_i (writedata),
        .re_i    (ram_re),
        .rdata_o (ram_q)
    );

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] oreg_q;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                oreg_q <= '0;
            end else if (!stall && vld_q[0]) begin
                oreg_q <= ram_q;
            end
        end
        assign stage_dat = oreg_q;
    end else begin : g_noreg
        assign stage_dat = ram_q;
    end

    // readdata only moves on a valid beat so it holds through stalls.
    assign readdatavalid = vld_q[LATENCY-1] & ~stall;
    assign readdata      = readdatavalid ? stage_dat : hold_q;

endmodule
